// File: rtl/sel_demux_reg_if.sv
// Bus between one producer and the two consumers of sel_demux_reg.
// cnt0/cnt1 carry live counts only when SEL_DEMUX_CNT_EN is defined.
interface sel_demux_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    // Per-channel FSM state, {ch1, ch0}; 1 = FULL.
    logic [1:0]       dbg_state;

    // Demux side.
    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data,
        output cnt0, cnt1, dbg_state
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
        input  cnt0, cnt1, dbg_state
    );
endinterface

// File: rtl/sel_demux_reg.sv
// Registered 1-to-2 demux with a single-entry holding register per output.
// Optional saturating delivery counters enabled by defining SEL_DEMUX_CNT_EN.
module sel_demux_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    sel_demux_reg_if.slave  bus
);
    // Handshake: a word moves across any valid/ready pair exactly at a rising
    // edge where both are high; valid never depends on ready, while in_ready is
    // a combinational function of the selected channel's state and its ready.

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;

    chan_state_e      st0_q, st0_d, st1_q, st1_d;
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             in_ready;
    logic             fill0, fill1;
    logic             drain0, drain1;

    always_comb begin
        in_ready = 1'b0;
        fill0    = 1'b0;
        fill1    = 1'b0;
        drain0   = (st0_q == FULL) && bus.out0_ready;
        drain1   = (st1_q == FULL) && bus.out1_ready;
        if (bus.in_sel) in_ready = (st1_q == EMPTY) || bus.out1_ready;
        else            in_ready = (st0_q == EMPTY) || bus.out0_ready;
        fill0 = bus.in_valid && in_ready && !bus.in_sel;
        fill1 = bus.in_valid && in_ready &&  bus.in_sel;
    end

    // A fill on the same edge as a drain wins, so the channel stays FULL.
    always_comb begin
        st0_d   = st0_q;
        data0_d = data0_q;
        case (st0_q)
            EMPTY: if (fill0) st0_d = FULL;
            FULL:  if (drain0 && !fill0) st0_d = EMPTY;
            default: st0_d = EMPTY;
        endcase
        if (fill0) data0_d = bus.in_data;
    end

    always_comb begin
        st1_d   = st1_q;
        data1_d = data1_q;
        case (st1_q)
            EMPTY: if (fill1) st1_d = FULL;
            FULL:  if (drain1 && !fill1) st1_d = EMPTY;
            default: st1_d = EMPTY;
        endcase
        if (fill1) data1_d = bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st0_q   <= EMPTY;
            st1_q   <= EMPTY;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_valid = (st0_q == FULL);
    assign bus.out1_valid = (st1_q == FULL);
    assign bus.out0_data  = data0_q;
    assign bus.out1_data  = data1_q;
    assign bus.dbg_state  = {st1_q, st0_q};

`ifdef SEL_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Counters saturate at all-ones instead of wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (drain0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
        if (drain1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;
`else
    assign bus.cnt0 = '0;
    assign bus.cnt1 = '0;
`endif

endmodule
